// File: rtl/avalon_wait_ram.sv
// avalon_wait_ram
//   Single-port Avalon-MM slave memory model for CPU benches. Serves 32-bit
//   word reads and byte-enabled writes, stalling every transaction with
//   waitrequest for a programmable number of cycles. A side-band loader
//   port preloads words (e.g. instruction images) before or during a run.
//
// Parameters
//   ADDR_W      word-address bits, depth = 2**ADDR_W words (ADDR_W <= 29)
//   WAIT_CYCLES fixed stall count per transaction, 0..15
//   LFSR_SEED   nonzero seed of the random-wait LFSR
//
// Ports
//   clk, reset_n                  clock, asynchronous active-low reset
//   address/read/write/writedata/byteenable   Avalon-MM request
//   waitrequest, readdata         Avalon-MM response
//   load_en/load_addr/load_data   loader full-word write, one per cycle
//   busy                          transaction in flight (FSM not IDLE)
//   err_rw                        sticky: read and write seen together
//
// Build option
//   AVALON_RAM_RANDOM_WAIT_EN  adds 0..3 pseudo-random stall cycles per
//                              transaction from a 16-bit LFSR.
//
// FSM states
//   state  | meaning
//   S_IDLE | no transaction; accept read/write, latch it, load the counter
//   S_WAIT | count down; loader activity freezes the countdown
//   S_DONE | completion cycle, waitrequest low, readdata valid

module avalon_wait_ram #(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned WAIT_CYCLES = 2,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic        waitrequest,
  output logic [31:0] readdata,
  input  logic        load_en,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  output logic        busy,
  output logic        err_rw
);

  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam logic [4:0]  WAIT_LD = 5'(WAIT_CYCLES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [ADDR_W-1:0]   idx_q, idx_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [3:0]          be_q, be_d;
  logic                is_wr_q, is_wr_d;
  logic                err_q, err_d;
  logic [31:0]         rdata_q;
  logic                accept;
  logic                commit_wr;
  logic                load_rd;
  logic [4:0]          wait_load;

  logic [31:0]         mem_q [DEPTH];

  // Upper and byte-offset address bits are deliberately ignored (aliasing).
  logic [ADDR_W-1:0]   bus_idx;
  logic [ADDR_W-1:0]   load_idx;
  logic                unused_addr;

  assign bus_idx     = address[ADDR_W+1:2];
  assign load_idx    = load_addr[ADDR_W+1:2];
  assign unused_addr = ^{address[31:ADDR_W+2], address[1:0],
                         load_addr[31:ADDR_W+2], load_addr[1:0]};

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [15:0] lfsr_q;

  // Fibonacci LFSR, taps 16,14,13,11; steps once per accepted transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= LFSR_SEED;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign wait_load = WAIT_LD + {3'b000, lfsr_q[1:0]};
`else
  logic [15:0] unused_seed;

  assign unused_seed = LFSR_SEED;
  assign wait_load   = WAIT_LD;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    is_wr_d   = is_wr_q;
    err_d     = err_q;
    accept    = 1'b0;
    commit_wr = 1'b0;
    load_rd   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          state_d = S_WAIT;
          idx_d   = bus_idx;
          wdata_d = writedata;
          be_d    = byteenable;
          // A simultaneous read+write is served as a write.
          is_wr_d = write;
          cnt_d   = wait_load;
          if (read && write) begin
            err_d = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Loader owns the memory port this cycle: freeze the countdown so
        // completion never coincides with a loader write.
        if (!load_en) begin
          if (cnt_q == 5'd0) begin
            state_d = S_DONE;
            if (is_wr_q) begin
              commit_wr = 1'b1;
            end else begin
              load_rd = 1'b1;
            end
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      is_wr_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      is_wr_q <= is_wr_d;
      err_q   <= err_d;
      if (load_rd) begin
        rdata_q <= mem_q[idx_q];
      end
    end
  end

  // Memory contents survive reset; reset only stops an in-flight commit
  // because the FSM is forced back to IDLE.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem_q[load_idx] <= load_data;
    end else if (commit_wr) begin
      if (be_q[0]) mem_q[idx_q][7:0]   <= wdata_q[7:0];
      if (be_q[1]) mem_q[idx_q][15:8]  <= wdata_q[15:8];
      if (be_q[2]) mem_q[idx_q][23:16] <= wdata_q[23:16];
      if (be_q[3]) mem_q[idx_q][31:24] <= wdata_q[31:24];
    end
  end

  assign waitrequest = (read || write) && (state_q != S_DONE);
  assign readdata    = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign err_rw      = err_q;

endmodule

// File: tb/tb_avalon_wait_ram.sv
module tb_avalon_wait_ram;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  // Instance A: WAIT_CYCLES = 2
  logic [31:0] addr_a = '0, wdata_a = '0;
  logic        rd_a = 1'b0, wr_a = 1'b0;
  logic [3:0]  be_a = '0;
  logic        wreq_a, busy_a, err_a;
  logic [31:0] rdata_a;

  // Instance B: WAIT_CYCLES = 0
  logic [31:0] addr_b = '0, wdata_b = '0;
  logic        rd_b = 1'b0, wr_b = 1'b0;
  logic [3:0]  be_b = '0;
  logic        wreq_b, busy_b, err_b;
  logic [31:0] rdata_b;

  // Shared loader
  logic        ld_en = 1'b0;
  logic [31:0] ld_addr = '0, ld_data = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct packed {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(2), .LFSR_SEED(16'hACE1)) u_dut_a (
    .clk(clk), .reset_n(rst_n),
    .address(addr_a), .read(rd_a), .write(wr_a), .writedata(wdata_a), .byteenable(be_a),
    .waitrequest(wreq_a), .readdata(rdata_a),
    .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data),
    .busy(busy_a), .err_rw(err_a)
  );

  avalon_wait_ram #(.ADDR_W(10), .WAIT_CYCLES(0), .LFSR_SEED(16'hACE1)) u_dut_b (
    .clk(clk), .reset_n(rst_n),
    .address(addr_b), .read(rd_b), .write(wr_b), .writedata(wdata_b), .byteenable(be_b),
    .waitrequest(wreq_b), .readdata(rdata_b),
    .load_en(ld_en), .load_addr(ld_addr), .load_data(ld_data),
    .busy(busy_b), .err_rw(err_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Completion monitors: a completion is a request seen with waitrequest low.
  always @(negedge clk) begin : mon_a
    exp_t e;
    #2;
    if (rst_n && (rd_a || wr_a) && !wreq_a) begin
      if (q_a.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_a_unexpected actual=completion expected=none");
      end else begin
        e = q_a.pop_front();
        if (e.is_rd) chk("sb_a_rdata", rdata_a, e.data);
        else         chk("sb_a_wr_done", {31'b0, wr_a}, 32'h1);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    #2;
    if (rst_n && (rd_b || wr_b) && !wreq_b) begin
      if (q_b.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_b_unexpected actual=completion expected=none");
      end else begin
        e = q_b.pop_front();
        if (e.is_rd) chk("sb_b_rdata", rdata_b, e.data);
        else         chk("sb_b_wr_done", {31'b0, wr_b}, 32'h1);
      end
    end
  end

  task automatic load_word(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // One transaction on instance A; expects WAIT_CYCLES+1 = 3 stall cycles
  // after the acceptance edge.
  task automatic bus_a(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] be,
                       input logic [31:0] exp, input string nm);
    int  stalls;
    bit  done;
    exp_t e;
    e.is_rd = r && !w;
    e.data  = exp;
    q_a.push_back(e);
    @(negedge clk);
    rd_a = r; wr_a = w; addr_a = a; wdata_a = d; be_a = be;
    #1 chk({nm, "_idle_wreq"}, {31'b0, wreq_a}, 32'h1);
    @(negedge clk);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!wreq_a) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    chk({nm, "_done"}, 32'(done), 32'h1);
    chk({nm, "_stalls"}, 32'(stalls), 32'd3);
    @(negedge clk);
    rd_a = 1'b0; wr_a = 1'b0;
  endtask

  initial begin
    int   stalls, k1, t1, t2;
    bit   done;
    exp_t e;

    // Reset state
    #1;
    chk("rst_busy",   {31'b0, busy_a}, 32'h0);
    chk("rst_rdata",  rdata_a, 32'h0);
    chk("rst_err",    {31'b0, err_a}, 32'h0);
    chk("rst_wreq0",  {31'b0, wreq_a}, 32'h0);
    chk("rst_rdata_b", rdata_b, 32'h0);
    rd_a = 1'b1;
    #1 chk("rst_wreq1", {31'b0, wreq_a}, 32'h1);
    rd_a = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Preload
    load_word(32'h04, 32'h2403FFF0);
    load_word(32'h10, 32'hAABBCCDD);
    load_word(32'h08, 32'h00000808);
    load_word(32'h0C, 32'h00000C0C);

    bus_a(1'b1, 1'b0, 32'h04, 32'h0, 4'h0, 32'h2403FFF0, "rd04");
    bus_a(1'b0, 1'b1, 32'h10, 32'h11223344, 4'b0101, 32'h0, "wr10");
    bus_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, "rd10");
    bus_a(1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0, 32'h2403FFF0, "rd_alias");
    bus_a(1'b0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, 32'h0, "wr_be0");
    bus_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, "rd_be0");

    // Master drops request mid-WAIT: completes internally, no error.
    @(negedge clk);
    rd_a = 1'b1; addr_a = 32'h04;
    @(negedge clk);
    rd_a = 1'b0;
    #1 chk("drop_busy", {31'b0, busy_a}, 32'h1);
    repeat (5) @(negedge clk);
    #1;
    chk("drop_idle", {31'b0, busy_a}, 32'h0);
    chk("drop_err",  {31'b0, err_a}, 32'h0);

    // Read and write together: served as write, sticky error.
    bus_a(1'b1, 1'b1, 32'h20, 32'h5, 4'hF, 32'h0, "rw20");
    #1 chk("err_set", {31'b0, err_a}, 32'h1);
    bus_a(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, 32'h5, "rd20");
    #1 chk("err_sticky", {31'b0, err_a}, 32'h1);

    // Loader active for 4 cycles during WAIT, writing the in-flight word.
    e.is_rd = 1'b1;
    e.data  = 32'hCAFEF00D;
    q_a.push_back(e);
    @(negedge clk);
    rd_a = 1'b1; addr_a = 32'h04;
    @(negedge clk);
    stalls = 0;
    done   = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (k < 4) begin
        ld_en = 1'b1; ld_addr = 32'h04; ld_data = 32'hCAFEF00D;
      end else begin
        ld_en = 1'b0;
      end
      #1;
      if (!wreq_a) begin
        done = 1'b1;
        break;
      end
      stalls++;
      @(negedge clk);
    end
    ld_en = 1'b0;
    chk("ldhold_done",   32'(done), 32'h1);
    chk("ldhold_stalls", 32'(stalls), 32'd7);
    @(negedge clk);
    rd_a = 1'b0;

    // WAIT_CYCLES=0 back-to-back reads on instance B.
    e.is_rd = 1'b1; e.data = 32'h00000808; q_b.push_back(e);
    e.is_rd = 1'b1; e.data = 32'h00000C0C; q_b.push_back(e);
    @(negedge clk);
    rd_b = 1'b1; addr_b = 32'h08;
    k1 = -1; t1 = -1; t2 = -1;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (!wreq_b) begin
        if (t1 < 0) begin
          t1 = cyc; k1 = k;
        end else begin
          t2 = cyc;
          break;
        end
      end
      @(negedge clk);
      if (t1 >= 0) addr_b = 32'h0C;
    end
    chk("b2b_first_lat", 32'(k1), 32'd2);
    chk("b2b_spacing",   32'(t2 - t1), 32'd3);
    @(negedge clk);
    rd_b = 1'b0;

    // Reset pulsed mid-write: aborted, memory unchanged.
    @(negedge clk);
    wr_a = 1'b1; addr_a = 32'h10; wdata_a = 32'h0; be_a = 4'hF;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    wr_a  = 1'b0;
    #1;
    chk("rstmid_busy", {31'b0, busy_a}, 32'h0);
    chk("rstmid_err",  {31'b0, err_a}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    bus_a(1'b1, 1'b0, 32'h10, 32'h0, 4'h0, 32'hAA22CC44, "rd_after_rst");

    repeat (3) @(negedge clk);
    chk("sb_a_empty", 32'(q_a.size()), 32'd0);
    chk("sb_b_empty", 32'(q_b.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
